// File: rtl/frame_push_sequencer.sv
// Frame builder: forwards an A-segment, then a B-segment, then one CRC word onto a shared
// valid/ready stream. It also drives the clear/update strobes of an external CRC engine.
module frame_push_sequencer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_a,
    input  logic [LEN_W-1:0]  len_b,
    input  logic              abort,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              crc_init,
    output logic              crc_en,
    output logic [DATA_W-1:0] crc_data,
    input  logic [DATA_W-1:0] crc_value,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {IDLE, PUSH_A, PUSH_B, CRC} state_t;

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   cnt_a_reg, cnt_a_next;
    logic [LEN_W-1:0]   cnt_b_reg, cnt_b_next;
    logic               done_reg, done_next;
    logic               aborted_reg, aborted_next;
    logic               abort_take;
    logic               a_xfer;
    logic               b_xfer;

    assign abort_take = abort && (state_reg != IDLE);
    assign a_xfer     = a_valid && out_ready;
    assign b_xfer     = b_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            cnt_a_reg   <= '0;
            cnt_b_reg   <= '0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_a_reg   <= cnt_a_next;
            cnt_b_reg   <= cnt_b_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_a_next   = cnt_a_reg;
        cnt_b_next   = cnt_b_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cnt_a_next = len_a;
                    cnt_b_next = len_b;
                    if (len_a != '0)
                        state_next = PUSH_A;
                    else if (len_b != '0)
                        state_next = PUSH_B;
                    else
                        state_next = CRC;
                end
            end
            PUSH_A: begin
                if (a_xfer) begin
                    cnt_a_next = cnt_a_reg - 1'b1;
                    if (cnt_a_reg == LEN_W'(1))
                        state_next = (cnt_b_reg != '0) ? PUSH_B : CRC;
                end
            end
            PUSH_B: begin
                if (b_xfer) begin
                    cnt_b_next = cnt_b_reg - 1'b1;
                    if (cnt_b_reg == LEN_W'(1))
                        state_next = CRC;
                end
            end
            CRC: begin
                if (out_ready) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides whatever the current state would have done this cycle.
        if (abort_take) begin
            state_next   = IDLE;
            cnt_a_next   = '0;
            cnt_b_next   = '0;
            done_next    = 1'b0;
            aborted_next = 1'b1;
        end
    end

    always_comb begin
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        crc_en    = 1'b0;
        crc_data  = '0;
        crc_init  = (state_reg == IDLE) && start && rstn;
        busy      = (state_reg != IDLE);
        done      = done_reg;
        aborted   = aborted_reg;
        if (!abort_take) begin
            case (state_reg)
                PUSH_A: begin
                    out_valid = a_valid;
                    out_data  = a_data;
                    a_ready   = out_ready;
                    crc_en    = a_xfer;
                    crc_data  = a_data;
                end
                PUSH_B: begin
                    out_valid = b_valid;
                    out_data  = b_data;
                    b_ready   = out_ready;
                    crc_en    = b_xfer;
                    crc_data  = b_data;
                end
                CRC: begin
                    out_valid = 1'b1;
                    out_data  = crc_value;
                    out_last  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
